// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch, load and store-drain requesters, with
// one transaction outstanding, fetch anti-starvation and flush-kill of read responses.
`default_nettype none

module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,

  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  output logic        ld_gnt_o,
  output logic        ld_rvalid_o,
  output logic [31:0] ld_rdata_o,

  input  logic        st_req_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  input  logic [3:0]  st_be_i,
  input  logic        st_urgent_i,
  output logic        st_gnt_o,

  input  logic        flush_i,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,

  output logic        busy_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_IF = 2'd0, OWN_LD = 2'd1, OWN_ST = 2'd2} owner_t;

  state_t        state, next_state;
  owner_t        owner, winner;
  logic          win_valid;
  logic          fetch_ok, load_ok;
  logic          grant;
  logic [31:0]   addr, wdata, rdata;
  logic [3:0]    be;
  logic          we;
  logic          kill;
  logic [CW-1:0] starve;
  logic          if_rvalid, ld_rvalid;

  // A flush in IDLE makes the (now wrong-path) fetch/load ineligible.
  assign fetch_ok = if_req_i & ~flush_i;
  assign load_ok  = ld_req_i & ~flush_i;

  always_comb begin
    winner    = OWN_IF;
    win_valid = 1'b1;
    if (st_req_i && st_urgent_i)              winner = OWN_ST;
    else if (fetch_ok && starve == STARVE_LIMIT) winner = OWN_IF;
    else if (load_ok)                         winner = OWN_LD;
    else if (st_req_i)                        winner = OWN_ST;
    else if (fetch_ok)                        winner = OWN_IF;
    else                                      win_valid = 1'b0;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_valid) next_state = REQ;
      REQ:     if (mem_gnt_i) next_state = (owner == OWN_ST) ? IDLE : WAIT;
      WAIT:    if (mem_rvalid_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      addr      <= '0;
      wdata     <= '0;
      be        <= '0;
      we        <= 1'b0;
      kill      <= 1'b0;
      starve    <= '0;
      rdata     <= '0;
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
    end else begin
      state <= next_state;

      if (state == IDLE && win_valid) begin
        owner <= winner;
        we    <= (winner == OWN_ST);
        wdata <= (winner == OWN_ST) ? st_data_i : 32'd0;
        be    <= (winner == OWN_ST) ? st_be_i : 4'd0;
        case (winner)
          OWN_LD:  addr <= ld_addr_i;
          OWN_ST:  addr <= st_addr_i;
          default: addr <= if_addr_i;
        endcase
        if (winner == OWN_IF)
          starve <= '0;
        else if (if_req_i && starve != STARVE_LIMIT)
          starve <= starve + 1'b1;
      end

      if (next_state == IDLE)
        kill <= 1'b0;
      else if (flush_i && state != IDLE && owner != OWN_ST)
        kill <= 1'b1;

      // A flush coinciding with the response kills it too.
      if_rvalid <= (state == WAIT) && mem_rvalid_i && !kill && !flush_i && (owner == OWN_IF);
      ld_rvalid <= (state == WAIT) && mem_rvalid_i && !kill && !flush_i && (owner == OWN_LD);
      if (state == WAIT && mem_rvalid_i)
        rdata <= mem_rdata_i;
    end
  end

  assign grant       = (state == REQ) && mem_gnt_i;
  assign if_gnt_o    = grant && (owner == OWN_IF);
  assign ld_gnt_o    = grant && (owner == OWN_LD);
  assign st_gnt_o    = grant && (owner == OWN_ST);

  assign if_rvalid_o = if_rvalid;
  assign ld_rvalid_o = ld_rvalid;
  assign if_rdata_o  = rdata;
  assign ld_rdata_o  = rdata;

  assign mem_req_o   = (state == REQ);
  assign mem_we_o    = we && (state == REQ);
  assign mem_addr_o  = addr;
  assign mem_wdata_o = wdata;
  assign mem_be_o    = be;

  assign busy_o      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the bench plays the memory port.
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        if_req_i, ld_req_i, st_req_i, st_urgent_i, flush_i;
  logic [31:0] if_addr_i, ld_addr_i, st_addr_i, st_data_i;
  logic [3:0]  st_be_i;
  logic        if_gnt_o, if_rvalid_o, ld_gnt_o, ld_rvalid_o, st_gnt_o;
  logic [31:0] if_rdata_o, ld_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_gnt_o(ld_gnt_o),
    .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
    .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
    .st_be_i(st_be_i), .st_urgent_i(st_urgent_i), .st_gnt_o(st_gnt_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in REQ; who: 0 fetch, 1 load, 2 store.
  task automatic serve(input int who, input logic [31:0] addr, input logic [31:0] data);
    chk("srv_req", mem_req_o, 1);
    chk("srv_addr", mem_addr_o, addr);
    chk("srv_we", mem_we_o, (who == 2));
    mem_gnt_i = 1'b1;
    #1;
    chk("srv_if_gnt", if_gnt_o, (who == 0));
    chk("srv_ld_gnt", ld_gnt_o, (who == 1));
    chk("srv_st_gnt", st_gnt_o, (who == 2));
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    if (who == 0) if_req_i = 1'b0;
    if (who == 1) ld_req_i = 1'b0;
    if (who == 2) st_req_i = 1'b0;
    if (who == 2) begin
      chk("srv_st_idle", busy_o, 0);
    end else begin
      chk("srv_wait_busy", busy_o, 1);
      chk("srv_wait_noreq", mem_req_o, 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data;
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      chk("srv_if_rvalid", if_rvalid_o, (who == 0));
      chk("srv_ld_rvalid", ld_rvalid_o, (who == 1));
      chk("srv_rdata", (who == 0) ? if_rdata_o : ld_rdata_o, data);
      chk("srv_idle", busy_o, 0);
    end
  endtask

  initial begin
    rstn_i = 1'b0;
    if_req_i = 0; ld_req_i = 0; st_req_i = 0; st_urgent_i = 0; flush_i = 0;
    if_addr_i = 0; ld_addr_i = 0; st_addr_i = 0; st_data_i = 0; st_be_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_req", mem_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rvalid", {if_rvalid_o, ld_rvalid_o}, 0);
    chk("rst_rdata", if_rdata_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    rstn_i = 1'b1;

    // Load beats fetch; fetch follows after the load response.
    ld_req_i = 1; ld_addr_i = 32'h100; if_req_i = 1; if_addr_i = 32'h200;
    @(negedge clk_i);
    serve(1, 32'h100, 32'h1111_1111);
    @(negedge clk_i);
    serve(0, 32'h200, 32'h2222_2222);

    // Four losses to back-to-back loads, then fetch is promoted.
    if_req_i = 1; if_addr_i = 32'h300;
    for (int i = 0; i < 4; i++) begin
      ld_req_i = 1; ld_addr_i = 32'h1000 + i;
      @(negedge clk_i);
      serve(1, 32'h1000 + i, 32'hA000 + i);
    end
    ld_req_i = 1; ld_addr_i = 32'h2000;
    @(negedge clk_i);
    serve(0, 32'h300, 32'h3333_3333);
    @(negedge clk_i);
    serve(1, 32'h2000, 32'h4444_4444);
    // Counter cleared: load wins again over a simultaneous fetch.
    if_req_i = 1; if_addr_i = 32'h310; ld_req_i = 1; ld_addr_i = 32'h2010;
    @(negedge clk_i);
    serve(1, 32'h2010, 32'h4545_4545);
    @(negedge clk_i);
    serve(0, 32'h310, 32'h3131_3131);

    // Urgent store beats everything.
    st_req_i = 1; st_urgent_i = 1; st_addr_i = 32'h400; st_data_i = 32'hCAFE_F00D; st_be_i = 4'h5;
    ld_req_i = 1; ld_addr_i = 32'h2020; if_req_i = 1; if_addr_i = 32'h320;
    @(negedge clk_i);
    chk("st_be", mem_be_o, 4'h5);
    chk("st_wdata", mem_wdata_o, 32'hCAFE_F00D);
    serve(2, 32'h400, 0);
    st_urgent_i = 0;
    @(negedge clk_i);
    chk("ld_read_be", mem_be_o, 0);
    chk("ld_read_wdata", mem_wdata_o, 0);
    serve(1, 32'h2020, 32'h5151_5151);
    @(negedge clk_i);
    serve(0, 32'h320, 32'h5252_5252);

    // Flush in IDLE: load ineligible, plain store still arbitrated.
    flush_i = 1; st_req_i = 1; st_addr_i = 32'h440; st_data_i = 32'h1234_5678; st_be_i = 4'hF;
    ld_req_i = 1; ld_addr_i = 32'h2030;
    @(negedge clk_i);
    flush_i = 0;
    chk("fl_idle_wdata", mem_wdata_o, 32'h1234_5678);
    serve(2, 32'h440, 0);
    @(negedge clk_i);
    serve(1, 32'h2030, 32'h6161_6161);

    // Fetch killed by a flush while waiting; late data never delivered.
    if_req_i = 1; if_addr_i = 32'h500;
    @(negedge clk_i);
    chk("kw_req", mem_req_o, 1);
    mem_gnt_i = 1;
    #1 chk("kw_gnt", if_gnt_o, 1);
    @(negedge clk_i);
    mem_gnt_i = 0; if_req_i = 0; flush_i = 1;
    @(negedge clk_i);
    flush_i = 0;
    chk("kw_busy", busy_o, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    mem_rvalid_i = 0;
    chk("kw_rvalid", if_rvalid_o, 0);
    chk("kw_idle", busy_o, 0);

    // Flush coinciding with the load response.
    ld_req_i = 1; ld_addr_i = 32'h2040;
    @(negedge clk_i);
    mem_gnt_i = 1;
    @(negedge clk_i);
    mem_gnt_i = 0; ld_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h5555; flush_i = 1;
    @(negedge clk_i);
    mem_rvalid_i = 0; flush_i = 0;
    chk("kc_rvalid", ld_rvalid_o, 0);
    chk("kc_idle", busy_o, 0);

    // Grant withheld 5 cycles; request and address stay put through a flush.
    if_req_i = 1; if_addr_i = 32'h600;
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", mem_req_o, 1);
      chk("hold_addr", mem_addr_o, 32'h600);
      chk("hold_nognt", if_gnt_o, 0);
      flush_i = (i == 2);
      @(negedge clk_i);
    end
    flush_i = 0;
    mem_gnt_i = 1;
    #1 chk("hold_gnt", if_gnt_o, 1);
    @(negedge clk_i);
    mem_gnt_i = 0; if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h6666_6666;
    @(negedge clk_i);
    mem_rvalid_i = 0;
    chk("hold_killed", if_rvalid_o, 0);

    // Asynchronous reset while waiting; a late response is ignored.
    ld_req_i = 1; ld_addr_i = 32'h700;
    @(negedge clk_i);
    mem_gnt_i = 1;
    @(negedge clk_i);
    mem_gnt_i = 0; ld_req_i = 0;
    chk("ar_busy_pre", busy_o, 1);
    rstn_i = 0;
    #1;
    chk("ar_busy", busy_o, 0);
    chk("ar_req", mem_req_o, 0);
    chk("ar_rdata", ld_rdata_o, 0);
    chk("ar_addr", mem_addr_o, 0);
    @(negedge clk_i);
    rstn_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    mem_rvalid_i = 0;
    chk("ar_late_ld", ld_rvalid_o, 0);
    chk("ar_late_if", if_rvalid_o, 0);
    chk("ar_idle", busy_o, 0);

    ld_req_i = 1; ld_addr_i = 32'h800;
    @(negedge clk_i);
    serve(1, 32'h800, 32'h8888_8888);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
